// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART receive/transmit blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_rx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Clock cycles per line bit (integer divide, remainder dropped).
  function automatic int clks_per_bit(input int clock, input int baud_rate);
    return clock / baud_rate;
  endfunction

  // Expected parity bit for a payload zero-extended to 9 bits; the zero
  // padding does not change the XOR reduction.
  function automatic logic parity_expected(input logic [8:0] payload, input int mode);
    logic bit_v;
    if (mode == PARITY_ODD) begin
      bit_v = ~^payload;
    end else begin
      bit_v = ^payload;
    end
    return bit_v;
  endfunction

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous UART line; resets to idle-high.
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx_async,
  output logic rx_sync
);

  logic [1:0] sync_q;
  logic [1:0] sync_d;

  // Shift the line one stage deeper each cycle.
  always_comb begin
    sync_d = {sync_q[0], rx_async};
  end

  // Synchroniser flops, idle-high after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= sync_d;
    end
  end

  assign rx_sync = sync_q[1];

endmodule

// File: rtl/axis_uart_rx_sv.sv
// UART receiver: mid-bit sampling, optional parity, stop-bit check,
// AXI-Stream master output with a single holding register.
module axis_uart_rx_sv
  import uart_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 32,
  parameter int CLOCK          = 100_000_000,
  parameter int BAUD_RATE      = 115_200,
  parameter int DATA_BITS      = 8,
  parameter int STOP_BITS      = 1,
  parameter int PARITY_BITS    = 0
) (
  input  logic                      aclk,
  input  logic                      areset,
  input  logic                      uart_rx,
  output logic [AXI_DATA_WIDTH-1:0] m_axis_tdata,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  output logic                      rx_done,
  output logic [1:0]                rx_error,
  output logic                      rx_overrun
);

  localparam int CPB     = clks_per_bit(CLOCK, BAUD_RATE);
  localparam int CNT_W   = $clog2(CPB);
  localparam int IDX_W   = $clog2(DATA_BITS + 1);
  localparam bit HAS_PAR = (PARITY_BITS != PARITY_NONE);

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CPB - 1);
  localparam logic [CNT_W-1:0] CNT_MID   = CNT_W'(CPB / 2 - 1);
  localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
  localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);

  if (DATA_BITS > AXI_DATA_WIDTH) begin : g_bad_width
    $error("DATA_BITS must not exceed AXI_DATA_WIDTH");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("DATA_BITS must be 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop_bits
    $error("STOP_BITS must be 1 or 2");
  end
  if (PARITY_BITS < 0 || PARITY_BITS > 2) begin : g_bad_parity
    $error("PARITY_BITS must be 0, 1 or 2");
  end
  if (CPB < 4) begin : g_bad_cpb
    $error("CLOCK/BAUD_RATE must be at least 4");
  end

  logic rx_s;

  uart_rx_sync u_sync (
    .clk      (aclk),
    .rst      (areset),
    .rx_async (uart_rx),
    .rx_sync  (rx_s)
  );

  uart_rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   frame_end_s;

  logic [AXI_DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic                      tvalid_q, tvalid_d;
  logic                      done_q, done_d;
  logic [1:0]                err_q, err_d;
  logic                      ovr_q, ovr_d;

  // Next-state logic: baud counter, bit index, shift register and error flags.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    perr_d      = perr_q;
    ferr_d      = ferr_q;
    frame_end_s = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = {CNT_W{1'b0}};
        if (rx_s == 1'b0) begin
          state_d = START;
          idx_d   = {IDX_W{1'b0}};
          perr_d  = 1'b0;
          ferr_d  = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (cnt_q == CNT_MID) begin
          cnt_d = {CNT_W{1'b0}};
          idx_d = {IDX_W{1'b0}};
          if (rx_s == 1'b0) begin
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          // LSB arrives first, so shifting right leaves it at bit 0.
          shift_d = {rx_s, shift_q[DATA_BITS-1:1]};
          if (idx_q == DATA_LAST) begin
            idx_d   = {IDX_W{1'b0}};
            state_d = HAS_PAR ? PARITY : STOP;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PARITY: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = {CNT_W{1'b0}};
          idx_d   = {IDX_W{1'b0}};
          state_d = STOP;
          if (rx_s != parity_expected(9'(shift_q), PARITY_BITS)) begin
            perr_d = 1'b1;
          end else begin
            perr_d = perr_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = {CNT_W{1'b0}};
          if (rx_s == 1'b0) begin
            ferr_d = 1'b1;
          end else begin
            ferr_d = ferr_q;
          end
          if (idx_q == STOP_LAST) begin
            // Back to IDLE straight away so a back-to-back start bit is caught.
            state_d     = IDLE;
            idx_d       = {IDX_W{1'b0}};
            frame_end_s = 1'b1;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = {CNT_W{1'b0}};
        idx_d   = {IDX_W{1'b0}};
      end
    endcase
  end

  // Completion strobes and AXIS holding register update.
  always_comb begin
    tdata_d  = tdata_q;
    tvalid_d = tvalid_q;
    done_d   = frame_end_s;
    err_d    = 2'b00;
    ovr_d    = 1'b0;
    if (tvalid_q && m_axis_tready) begin
      tvalid_d = 1'b0;
    end else begin
      tvalid_d = tvalid_q;
    end
    if (frame_end_s) begin
      err_d = {perr_q, ferr_d};
      if (ferr_d) begin
        // Framing error: drop the payload, holding register untouched.
        tdata_d = tdata_q;
      end else if (!tvalid_q || m_axis_tready) begin
        tdata_d  = AXI_DATA_WIDTH'(shift_q);
        tvalid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else begin
      err_d = 2'b00;
    end
  end

  // State, datapath and output registers with synchronous reset.
  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q  <= IDLE;
      cnt_q    <= {CNT_W{1'b0}};
      idx_q    <= {IDX_W{1'b0}};
      shift_q  <= {DATA_BITS{1'b0}};
      perr_q   <= 1'b0;
      ferr_q   <= 1'b0;
      tdata_q  <= {AXI_DATA_WIDTH{1'b0}};
      tvalid_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 2'b00;
      ovr_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      shift_q  <= shift_d;
      perr_q   <= perr_d;
      ferr_q   <= ferr_d;
      tdata_q  <= tdata_d;
      tvalid_q <= tvalid_d;
      done_q   <= done_d;
      err_q    <= err_d;
      ovr_q    <= ovr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign rx_done       = done_q;
  assign rx_error      = err_q;
  assign rx_overrun    = ovr_q;

endmodule

// File: tb/tb_axis_uart_rx_sv.sv
// Bench for axis_uart_rx_sv: one 8N1 and one 8E1 instance at 10 clocks/bit.
module tb_axis_uart_rx_sv;

  logic             clk = 1'b0;
  logic             areset;
  logic [1:0]       rx_line;
  logic [1:0]       tready;
  logic [1:0][31:0] tdata_w;
  logic [1:0]       tvalid_w;
  logic [1:0]       done_w;
  logic [1:0][1:0]  err_w;
  logic [1:0]       ovr_w;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  axis_uart_rx_sv #(
    .AXI_DATA_WIDTH(32), .CLOCK(1_000_000), .BAUD_RATE(100_000),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_BITS(0)
  ) dut_n (
    .aclk(clk), .areset(areset), .uart_rx(rx_line[0]),
    .m_axis_tdata(tdata_w[0]), .m_axis_tvalid(tvalid_w[0]), .m_axis_tready(tready[0]),
    .rx_done(done_w[0]), .rx_error(err_w[0]), .rx_overrun(ovr_w[0])
  );

  axis_uart_rx_sv #(
    .AXI_DATA_WIDTH(32), .CLOCK(1_000_000), .BAUD_RATE(100_000),
    .DATA_BITS(8), .STOP_BITS(1), .PARITY_BITS(1)
  ) dut_e (
    .aclk(clk), .areset(areset), .uart_rx(rx_line[1]),
    .m_axis_tdata(tdata_w[1]), .m_axis_tvalid(tvalid_w[1]), .m_axis_tready(tready[1]),
    .rx_done(done_w[1]), .rx_error(err_w[1]), .rx_overrun(ovr_w[1])
  );

  // Event monitor: counts pulses and handshakes as seen just before each edge.
  int          done_cnt [2];
  int          acc_cnt  [2];
  int          ovr_cnt  [2];
  logic [1:0]  last_err [2];
  logic [31:0] last_acc [2];

  initial begin
    for (int i = 0; i < 2; i++) begin
      done_cnt[i] = 0; acc_cnt[i] = 0; ovr_cnt[i] = 0;
      last_err[i] = 2'b00; last_acc[i] = 32'h0;
    end
  end

  always @(posedge clk) begin
    for (int m = 0; m < 2; m++) begin
      if (done_w[m]) begin
        done_cnt[m] <= done_cnt[m] + 1;
        last_err[m] <= err_w[m];
      end
      if (ovr_w[m]) ovr_cnt[m] <= ovr_cnt[m] + 1;
      if (tvalid_w[m] && tready[m]) begin
        acc_cnt[m]  <= acc_cnt[m] + 1;
        last_acc[m] <= tdata_w[m];
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bit_wait();
    repeat (10) @(negedge clk);
  endtask

  // Bit-accurate UART transmitter: start, 8 data LSB first, optional parity, stop.
  task automatic uart_send(input int sel, input logic [7:0] data, input logic has_par,
                           input logic par_bit, input logic stop_bit);
    @(negedge clk);
    rx_line[sel] = 1'b0;
    bit_wait();
    for (int b = 0; b < 8; b++) begin
      rx_line[sel] = data[b];
      bit_wait();
    end
    if (has_par) begin
      rx_line[sel] = par_bit;
      bit_wait();
    end
    rx_line[sel] = stop_bit;
    bit_wait();
    rx_line[sel] = 1'b1;
    bit_wait();
  endtask

  typedef struct {
    int         sel;
    logic [7:0] data;
    logic       par_bit;
    logic       stop_bit;
    logic [1:0] exp_err;
    int         exp_acc;
  } vec_t;

  vec_t vecs [9];

  int          d0, a0, o0, lat;
  logic [31:0] lat_data;
  logic [9:0]  frame;

  initial begin
    // sel, data, parity bit on line, stop bit on line, rx_error, deliveries
    vecs[0] = '{0, 8'hA5, 1'b0, 1'b1, 2'b00, 1};
    vecs[1] = '{0, 8'h55, 1'b0, 1'b0, 2'b01, 0};
    vecs[2] = '{0, 8'h00, 1'b0, 1'b1, 2'b00, 1};
    vecs[3] = '{0, 8'hFF, 1'b0, 1'b1, 2'b00, 1};
    vecs[4] = '{1, 8'h03, 1'b1, 1'b1, 2'b10, 1};
    vecs[5] = '{1, 8'h03, 1'b0, 1'b1, 2'b00, 1};
    vecs[6] = '{1, 8'h81, 1'b0, 1'b1, 2'b00, 1};
    vecs[7] = '{1, 8'h5A, 1'b0, 1'b0, 2'b01, 0};
    vecs[8] = '{1, 8'h07, 1'b0, 1'b0, 2'b11, 0};

    areset  = 1'b1;
    rx_line = 2'b11;
    tready  = 2'b11;
    repeat (3) @(negedge clk);
    check("reset_n_outputs", {tdata_w[0], tvalid_w[0], done_w[0], err_w[0], ovr_w[0]}, 64'h0);
    check("reset_e_outputs", {tdata_w[1], tvalid_w[1], done_w[1], err_w[1], ovr_w[1]}, 64'h0);
    areset = 1'b0;
    repeat (5) @(negedge clk);

    // Table-driven frames with tready held high.
    for (int v = 0; v < 9; v++) begin
      d0 = done_cnt[vecs[v].sel];
      a0 = acc_cnt[vecs[v].sel];
      uart_send(vecs[v].sel, vecs[v].data, vecs[v].sel == 1, vecs[v].par_bit, vecs[v].stop_bit);
      repeat (20) @(negedge clk);
      check($sformatf("vec%0d_done", v), done_cnt[vecs[v].sel] - d0, 1);
      check($sformatf("vec%0d_err", v), last_err[vecs[v].sel], vecs[v].exp_err);
      check($sformatf("vec%0d_acc", v), acc_cnt[vecs[v].sel] - a0, vecs[v].exp_acc);
      if (vecs[v].exp_acc != 0)
        check($sformatf("vec%0d_data", v), last_acc[vecs[v].sel], {24'h0, vecs[v].data});
      check($sformatf("vec%0d_tvalid_idle", v), tvalid_w[vecs[v].sel], 1'b0);
    end

    // Overrun: consumer stalled across two good frames.
    tready[0] = 1'b0;
    d0 = done_cnt[0]; a0 = acc_cnt[0]; o0 = ovr_cnt[0];
    uart_send(0, 8'h11, 1'b0, 1'b0, 1'b1);
    check("ovr_first_valid", tvalid_w[0], 1'b1);
    check("ovr_first_data", tdata_w[0], 32'h11);
    uart_send(0, 8'h22, 1'b0, 1'b0, 1'b1);
    check("ovr_pulse", ovr_cnt[0] - o0, 1);
    check("ovr_done_count", done_cnt[0] - d0, 2);
    check("ovr_data_kept", tdata_w[0], 32'h11);
    check("ovr_valid_kept", tvalid_w[0], 1'b1);
    @(negedge clk);
    tready[0] = 1'b1;
    @(negedge clk);
    check("ovr_drain_valid", tvalid_w[0], 1'b0);
    check("ovr_drain_count", acc_cnt[0] - a0, 1);
    check("ovr_drain_data", last_acc[0], 32'h11);
    repeat (10) @(negedge clk);

    // Short low glitch on an idle line must be rejected.
    d0 = done_cnt[0];
    @(negedge clk);
    rx_line[0] = 1'b0;
    repeat (4) @(negedge clk);
    rx_line[0] = 1'b1;
    repeat (40) @(negedge clk);
    check("glitch_no_done", done_cnt[0] - d0, 0);
    uart_send(0, 8'h7E, 1'b0, 1'b0, 1'b1);
    repeat (10) @(negedge clk);
    check("glitch_next_done", done_cnt[0] - d0, 1);
    check("glitch_next_err", last_err[0], 2'b00);
    check("glitch_next_data", last_acc[0], 32'h7E);

    // Reset in the middle of 0xC3 data bits, released at a bit boundary.
    d0 = done_cnt[0]; a0 = acc_cnt[0];
    frame = {1'b1, 8'hC3, 1'b0};
    @(negedge clk);
    for (int b = 0; b < 5; b++) begin
      rx_line[0] = frame[b];
      bit_wait();
    end
    areset = 1'b1;
    for (int b = 5; b < 10; b++) begin
      rx_line[0] = frame[b];
      @(negedge clk);
      if (b == 5)
        check("rst_mid_outputs", {tdata_w[0], tvalid_w[0], done_w[0], err_w[0], ovr_w[0]}, 64'h0);
      repeat (9) @(negedge clk);
    end
    check("rst_end_outputs", {tdata_w[0], tvalid_w[0], done_w[0], err_w[0], ovr_w[0]}, 64'h0);
    rx_line[0] = 1'b1;
    areset = 1'b0;
    repeat (20) @(negedge clk);

    // 0x3C after reset, with start-bit to tvalid latency measured.
    frame    = {1'b1, 8'h3C, 1'b0};
    lat      = -1;
    lat_data = 32'h0;
    @(negedge clk);
    rx_line[0] = frame[0];
    for (int c = 1; c < 200; c++) begin
      @(negedge clk);
      rx_line[0] = (c < 100) ? frame[c / 10] : 1'b1;
      if (tvalid_w[0] && lat < 0) begin
        lat      = c;
        lat_data = tdata_w[0];
      end
    end
    check("lat_cycles", lat, 98);
    check("lat_data", lat_data, 32'h3C);
    check("rst_done_count", done_cnt[0] - d0, 1);
    check("rst_acc_count", acc_cnt[0] - a0, 1);
    check("rst_acc_data", last_acc[0], 32'h3C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
